fpu: RTL and testbench



---
 rtl/fpu_pkg.sv | 68 ++++++
 rtl/fpu_addsub.sv | 116 +++++++++++
 rtl/fpu.sv | 137 +++++++++++++
 tb/tb_fpu.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared types, constants and the common round/pack helper for the binary32
// arithmetic unit.
//
// Configuration macro: FPU_ROUND_EN
//   defined   -> round-to-nearest-even using guard/round/sticky bits
//   undefined -> round-toward-zero (guard/round/sticky discarded)
// -----------------------------------------------------------------------------
package fpu_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MUL  = 2'b10,
        OP_RSVD = 2'b11
    } fpu_op_e;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;
    localparam int          BIAS    = 127;

`ifdef FPU_ROUND_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    // Round and pack a normalized magnitude.
    //   mant[26]   : hidden bit (must be 1 unless the value is zero)
    //   mant[25:3] : fraction
    //   mant[2:0]  : guard, round, sticky
    //   exp        : biased exponent, signed so underflow shows as <= 0
    // Overflow saturates to signed infinity; underflow flushes to signed zero.
    function automatic logic [31:0] round_pack(input logic               sign,
                                               input logic signed [10:0] exp,
                                               input logic [26:0]        mant);
        logic [24:0]        m;
        logic signed [10:0] e;
        logic               inc;
        logic [31:0]        r;
        // Nearest-even: round up when guard is set and either something below
        // it is set or the kept LSB is odd (tie goes to even).
        inc = ROUND_EN & mant[2] & (mant[3] | mant[1] | mant[0]);
        m   = {1'b0, mant[26:3]} + {24'd0, inc};
        e   = exp;
        // A rounding carry out of the mantissa re-normalizes by one place.
        if (m[24]) begin
            m = m >> 1;
            e = e + 11'sd1;
        end
        if (e >= 11'sd255)
            r = sign ? NEG_INF : POS_INF;
        else if (e <= 11'sd0)
            r = {sign, 31'd0};
        else
            r = {sign, e[7:0], m[22:0]};
        return r;
    endfunction

endpackage

// File: rtl/fpu_addsub.sv
// -----------------------------------------------------------------------------
// fpu_addsub
// Combinational align / add / normalize / round path for finite binary32
// operands. Denormal inputs are treated as signed zero. NaN/inf handling is
// done by the caller.
//
// Ports:
//   a, b    in  32  operands (b already carries the effective sign for sub)
//   sum     out 32  rounded binary32 result
//
// Rounding mode follows FPU_ROUND_EN through fpu_pkg::round_pack.
// -----------------------------------------------------------------------------
module fpu_addsub
    import fpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    fp32_t fa, fb;
    assign fa = fp32_t'(a);
    assign fb = fp32_t'(b);

    logic [23:0]        ma, mb;
    logic [7:0]         big_e, small_e, diff;
    logic [23:0]        big_m, small_m;
    logic               big_s, small_s;
    logic [26:0]        big_ext, small_ext, shifted, mask, al, d, norm;
    logic [27:0]        add28;
    logic [4:0]         lz;
    logic               found;
    logic signed [10:0] exp_n;
    logic [26:0]        mant_n;

    assign ma = (fa.exp != 8'd0) ? {1'b1, fa.frac} : 24'd0;
    assign mb = (fb.exp != 8'd0) ? {1'b1, fb.frac} : 24'd0;

    always_comb begin
        big_e     = fa.exp;
        big_m     = ma;
        big_s     = fa.sign;
        small_e   = fb.exp;
        small_m   = mb;
        small_s   = fb.sign;
        diff      = 8'd0;
        big_ext   = 27'd0;
        small_ext = 27'd0;
        shifted   = 27'd0;
        mask      = 27'd0;
        al        = 27'd0;
        d         = 27'd0;
        norm      = 27'd0;
        add28     = 28'd0;
        lz        = 5'd0;
        found     = 1'b0;
        exp_n     = 11'sd0;
        mant_n    = 27'd0;
        sum       = 32'd0;

        // Order by magnitude so the subtraction below never goes negative.
        if ({fb.exp, mb} > {fa.exp, ma}) begin
            big_e   = fb.exp;
            big_m   = mb;
            big_s   = fb.sign;
            small_e = fa.exp;
            small_m = ma;
            small_s = fa.sign;
        end

        diff      = big_e - small_e;
        big_ext   = {big_m, 3'b000};
        small_ext = {small_m, 3'b000};

        // Right-align the smaller operand; everything shifted past the
        // round bit is ORed into the sticky bit.
        if (diff >= 8'd27) begin
            al = {26'd0, |small_m};
        end else begin
            shifted = small_ext >> diff;
            mask    = (27'd1 << diff) - 27'd1;
            al      = {shifted[26:1], shifted[0] | (|(small_ext & mask))};
        end

        if (big_s == small_s) begin
            add28 = {1'b0, big_ext} + {1'b0, al};
            if (add28[27]) begin
                mant_n = {add28[27:2], add28[1] | add28[0]};
                exp_n  = $signed({3'b000, big_e}) + 11'sd1;
            end else begin
                mant_n = add28[26:0];
                exp_n  = $signed({3'b000, big_e});
            end
            // Also covers zero+zero with equal signs (zero mantissa flushes
            // to a zero carrying that sign).
            sum = round_pack(big_s, exp_n, mant_n);
        end else begin
            d = big_ext - al;
            if (d == 27'd0) begin
                sum = 32'd0;
            end else begin
                for (int i = 26; i >= 0; i--) begin
                    if (!found) begin
                        if (d[i]) found = 1'b1;
                        else      lz    = lz + 5'd1;
                    end
                end
                norm   = d << lz;
                mant_n = norm;
                exp_n  = $signed({3'b000, big_e}) - $signed({6'd0, lz});
                sum    = round_pack(big_s, exp_n, mant_n);
            end
        end
    end

endmodule

// File: rtl/fpu.sv
// -----------------------------------------------------------------------------
// fpu
// Binary32 add / subtract / multiply unit, single issue, one-cycle latency.
// The operation is computed combinationally from the sampled inputs and
// captured in the output register on the accepting edge, so the response is
// visible in the cycle after that edge. Outputs come only from flops.
//
// Handshake: a request is accepted on every rising edge where valid=1 and
// reset is deasserted; there is no backpressure. ready is a one-cycle pulse
// marking that result holds the response to the previous accepted request.
// result holds its last value while idle.
//
// Ports:
//   clk     in  1   clock
//   reset   in  1   synchronous, active-low reset
//   din1    in  32  operand A
//   din2    in  32  operand B
//   valid   in  1   request strobe
//   op_sel  in  2   00 add, 01 sub, 10 mul, 11 reserved (returns qNaN)
//   result  out 32  binary32 result
//   ready   out 1   response strobe
//
// Configuration macro: FPU_ROUND_EN (round-to-nearest-even when defined,
// truncation otherwise).
// -----------------------------------------------------------------------------
module fpu
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] din1,
    input  logic [31:0] din2,
    input  logic        valid,
    input  logic [1:0]  op_sel,
    output logic [31:0] result,
    output logic        ready
);

    fp32_t   fa, fb;
    fpu_op_e op;
    assign fa = fp32_t'(din1);
    assign fb = fp32_t'(din2);
    assign op = fpu_op_e'(op_sel);

    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    assign a_nan  = (fa.exp == 8'hFF) && (fa.frac != 23'd0);
    assign b_nan  = (fb.exp == 8'hFF) && (fb.frac != 23'd0);
    assign a_inf  = (fa.exp == 8'hFF) && (fa.frac == 23'd0);
    assign b_inf  = (fb.exp == 8'hFF) && (fb.frac == 23'd0);
    assign a_zero = (fa.exp == 8'd0);
    assign b_zero = (fb.exp == 8'd0);

    // Subtraction is addition with B's sign flipped.
    logic        b_sign_eff;
    logic [31:0] addsub_res;
    assign b_sign_eff = fb.sign ^ (op == OP_SUB);

    fpu_addsub u_addsub (
        .a   (din1),
        .b   ({b_sign_eff, din2[30:0]}),
        .sum (addsub_res)
    );

    // Multiply datapath.
    logic               mul_sign;
    logic [47:0]        prod;
    logic signed [10:0] mul_exp;
    logic [26:0]        mul_mant;
    logic [31:0]        mul_res;

    assign mul_sign = fa.sign ^ fb.sign;
    assign prod     = {1'b1, fa.frac} * {1'b1, fb.frac};

    always_comb begin
        mul_exp  = $signed({3'b000, fa.exp}) + $signed({3'b000, fb.exp})
                   - 11'(BIAS);
        mul_mant = 27'd0;
        mul_res  = 32'd0;
        // Product of two [1,2) mantissas lies in [1,4): at most one
        // normalizing right shift.
        if (prod[47]) begin
            mul_mant = {prod[47:22], |prod[21:0]};
            mul_exp  = mul_exp + 11'sd1;
        end else begin
            mul_mant = {prod[46:21], |prod[20:0]};
        end
        if (a_zero || b_zero)
            mul_res = {mul_sign, 31'd0};
        else
            mul_res = round_pack(mul_sign, mul_exp, mul_mant);
    end

    // Special-case selection.
    logic [31:0] next_result;

    always_comb begin
        next_result = QNAN;
        case (op)
            OP_ADD, OP_SUB: begin
                if (a_nan || b_nan)
                    next_result = QNAN;
                else if (a_inf && b_inf)
                    next_result = (fa.sign != b_sign_eff) ? QNAN
                                  : {fa.sign, 8'hFF, 23'd0};
                else if (a_inf)
                    next_result = {fa.sign, 8'hFF, 23'd0};
                else if (b_inf)
                    next_result = {b_sign_eff, 8'hFF, 23'd0};
                else
                    next_result = addsub_res;
            end
            OP_MUL: begin
                if (a_nan || b_nan)
                    next_result = QNAN;
                else if ((a_inf && b_zero) || (a_zero && b_inf))
                    next_result = QNAN;
                else if (a_inf || b_inf)
                    next_result = {mul_sign, 8'hFF, 23'd0};
                else
                    next_result = mul_res;
            end
            default: next_result = QNAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            result <= 32'd0;
            ready  <= 1'b0;
        end else begin
            ready <= valid;
            if (valid)
                result <= next_result;
        end
    end

endmodule

// File: tb/tb_fpu.sv
// -----------------------------------------------------------------------------
// tb_fpu
// Randomized and directed stimulus for the binary32 unit. Expected responses
// are queued at issue time and popped by an independent monitor whenever the
// DUT raises ready. The reference model converts operands to double precision,
// does the arithmetic there (exact for the operand ranges generated), then
// rounds/packs back to binary32.
// -----------------------------------------------------------------------------
module tb_fpu;

    logic        clk;
    logic        reset;
    logic [31:0] din1;
    logic [31:0] din2;
    logic        valid;
    logic [1:0]  op_sel;
    logic [31:0] result;
    logic        ready;

    fpu dut (
        .clk    (clk),
        .reset  (reset),
        .din1   (din1),
        .din2   (din2),
        .valid  (valid),
        .op_sel (op_sel),
        .result (result),
        .ready  (ready)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_hold = 32'd0;
    logic        rst_last = 1'b0;
    logic        acc      = 1'b0;

    // What the DUT saw on the last rising edge.
    always @(posedge clk) begin
        rst_last <= !reset;
        acc      <= reset && valid;
    end

    // ---------------- reference model ----------------
    function automatic real to_real(input logic [31:0] x);
        logic [10:0] e11;
        if (x[30:23] == 8'd0) return 0.0;
        e11 = {3'b000, x[30:23]} + 11'd896;
        return $bitstoreal({x[31], e11, x[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] from_real(input real r);
        logic [63:0] bits;
        logic [24:0] m;
        int          e;
        bits = $realtobits(r);
        e    = int'(bits[62:52]) - 896;
        m    = {2'b01, bits[51:29]};
`ifdef FPU_ROUND_EN
        if (bits[28] && (bits[29] || (|bits[27:0]))) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e = e + 1;
        end
`endif
        if (e >= 255) return {bits[63], 8'hFF, 23'd0};
        if (e <= 0)   return {bits[63], 31'd0};
        return {bits[63], 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [1:0]  op);
        logic a_nan, b_nan, a_inf, b_inf, a_z, b_z, sbe;
        real  r;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        a_z   = (a[30:23] == 8'd0);
        b_z   = (b[30:23] == 8'd0);
        if (op == 2'b11 || a_nan || b_nan) return 32'h7FC0_0000;
        if (op == 2'b10) begin
            if ((a_inf && b_z) || (a_z && b_inf)) return 32'h7FC0_0000;
            if (a_inf || b_inf) return {a[31] ^ b[31], 8'hFF, 23'd0};
            if (a_z || b_z)     return {a[31] ^ b[31], 31'd0};
            return from_real(to_real(a) * to_real(b));
        end
        sbe = b[31] ^ (op == 2'b01);
        if (a_inf && b_inf) return (a[31] != sbe) ? 32'h7FC0_0000 : {a[31], 8'hFF, 23'd0};
        if (a_inf) return {a[31], 8'hFF, 23'd0};
        if (b_inf) return {sbe, 8'hFF, 23'd0};
        if (a_z && b_z) return {a[31] & sbe, 31'd0};
        r = to_real(a) + to_real({sbe, b[30:0]});
        if (r == 0.0) return 32'd0;
        return from_real(r);
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] special_val();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'h7F80_0000;
            3:       return 32'hFF80_0000;
            4:       return 32'h7FC0_0001;
            5:       return 32'hFFA0_0000;
            default: return 32'h0001_2345;
        endcase
    endfunction

    function automatic logic [31:0] rand_fp(input int e_lo, input int e_hi);
        logic [31:0] f;
        f = $urandom;
        return {f[31], 8'($urandom_range(e_hi, e_lo)), f[22:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [31:0] e);
        @(negedge clk);
        reset  = 1'b1;
        din1   = a;
        din2   = b;
        op_sel = op;
        valid  = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic issue_model(input logic [31:0] a, input logic [31:0] b,
                               input logic [1:0] op);
        issue(a, b, op, model(a, b, op));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid = 1'b0;
            din1  = $urandom;
            din2  = $urandom;
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_last) begin
            chk("reset_result", result, 32'd0);
            chk("reset_ready", {31'd0, ready}, 32'd0);
            exp_hold = 32'd0;
        end else begin
            chk("ready_pulse", {31'd0, ready}, {31'd0, acc});
            if (ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_ready: got ready with no request outstanding");
                end else begin
                    e = exp_q.pop_front();
                    chk("result", result, e);
                    exp_hold = e;
                end
            end else begin
                chk("hold", result, exp_hold);
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] a, b;
        logic [1:0]  op;
        int          ea, eb;

        reset  = 1'b0;
        valid  = 1'b1;
        din1   = 32'h3F80_0000;
        din2   = 32'h4000_0000;
        op_sel = 2'b00;
        // Two reset edges with valid high: both must be ignored.
        repeat (2) @(negedge clk);
        reset = 1'b1;
        valid = 1'b0;
        idle(1);

        // Directed cases; add and multiply back to back.
        issue(32'h3F80_0000, 32'h4000_0000, 2'b00, 32'h4040_0000);
        issue(32'h4040_0000, 32'h4020_0000, 2'b10, 32'h40F0_0000);
        idle(1);
        issue(32'h3F80_0000, 32'h3F80_0000, 2'b01, 32'h0000_0000);
        issue(32'h7F7F_FFFF, 32'h4000_0000, 2'b10, 32'h7F80_0000);
        issue(32'h7F80_0000, 32'h7F80_0000, 2'b01, 32'h7FC0_0000);
        issue(32'h0000_0000, 32'h7F80_0000, 2'b10, 32'h7FC0_0000);
        issue(32'h1234_5678, 32'h9ABC_DEF0, 2'b11, 32'h7FC0_0000);
        idle(3);
        // Far-apart exponents: only the sticky bit of the small operand survives.
        issue(32'h3F80_0000, 32'h3080_0000, 2'b00, 32'h3F80_0000);
`ifdef FPU_ROUND_EN
        issue(32'h3F80_0000, 32'h3080_0000, 2'b01, 32'h3F80_0000);
`else
        issue(32'h3F80_0000, 32'h3080_0000, 2'b01, 32'h3F7F_FFFF);
`endif
        // 1.5 * 1.5 = 2.25 (normalizing shift in the multiplier).
        issue(32'h3FC0_0000, 32'h3FC0_0000, 2'b10, 32'h4010_0000);
        // Denormal operand acts as zero: -0 * 2.0 -> -0.
        issue(32'h8000_1234, 32'h4000_0000, 2'b10, 32'h8000_0000);
        idle(2);

        // Reset in the middle of activity clears result and ready.
        issue(32'h4000_0000, 32'h4000_0000, 2'b00, 32'h4080_0000);
        @(negedge clk);
        valid = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        valid = 1'b0;
        idle(2);

        // Randomized traffic.
        for (int n = 0; n < 800; n++) begin
            op = 2'($urandom_range(0, 15) == 0 ? 3 : $urandom_range(0, 2));
            if (op == 2'b10) begin
                a = rand_fp(1, 254);
                b = rand_fp(1, 254);
            end else begin
                // Keep exponent gap <= 28 so the double-precision sum is exact.
                ea = $urandom_range(1, 254);
                eb = ea + $urandom_range(0, 56) - 28;
                if (eb < 1)   eb = 1;
                if (eb > 254) eb = 254;
                a = rand_fp(ea, ea);
                b = rand_fp(eb, eb);
                if ($urandom_range(0, 5) == 0) b = {b[31], a[30:0]};
            end
            if ($urandom_range(0, 11) == 0) a = special_val();
            if ($urandom_range(0, 11) == 0) b = special_val();
            issue_model(a, b, op);
            if ($urandom_range(0, 9) < 3) idle($urandom_range(1, 3));
        end

        idle(4);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
